// File: rtl/video_timing_generator.sv
// Raster timing generator with built-in test patterns (colour bars, gradient,
// checkerboard, grey). Every output is registered one cycle behind the counters.
module video_timing_generator #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic       pixelClock,
  input  logic       resetN,
  input  logic       enable,
  input  logic [1:0] patternSelect,
  output logic       DE,
  output logic [1:0] controlBus,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Counters are kept wide enough for the gradient (bits 7:0) and checker (bit 4) taps.
  localparam int HW      = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
  localparam int VW      = ($clog2(V_TOTAL) > 5) ? $clog2(V_TOTAL) : 5;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = ($clog2(BAR_W) > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BW-1:0] BAR_LAST     = BW'(BAR_W - 1);

  localparam logic [1:0] PAT_BARS    = 2'd0;
  localparam logic [1:0] PAT_GRAD    = 2'd1;
  localparam logic [1:0] PAT_CHECKER = 2'd2;
  localparam logic [1:0] PAT_GREY    = 2'd3;

  logic [HW-1:0] hCount_q, hCount_d;
  logic [VW-1:0] vCount_q, vCount_d;
  logic [BW-1:0] barWidth_q, barWidth_d;
  logic [2:0]    barIndex_q, barIndex_d;
  logic [1:0]    pattern_q, pattern_d;

  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          frameStart_q, frameStart_d;
  logic [23:0]   rgb_q, rgb_d;

  logic          atOrigin;
  logic [1:0]    activePattern;
  logic [23:0]   barColour;
  logic [23:0]   colour;

  assign atOrigin = (hCount_q == '0) && (vCount_q == '0);
  // The first pixel of a frame already uses the newly sampled selection.
  assign activePattern = atOrigin ? patternSelect : pattern_q;

  always_comb begin
    hCount_d = hCount_q;
    vCount_d = vCount_q;
    if (!enable) begin
      hCount_d = '0;
      vCount_d = '0;
    end else if (hCount_q == H_LAST) begin
      hCount_d = '0;
      vCount_d = (vCount_q == V_LAST) ? '0 : vCount_q + VW'(1);
    end else begin
      hCount_d = hCount_q + HW'(1);
    end
  end

  always_comb begin
    barWidth_d = barWidth_q;
    barIndex_d = barIndex_q;
    if (hCount_d == '0) begin
      barWidth_d = '0;
      barIndex_d = '0;
    end else if (barWidth_q == BAR_LAST) begin
      barWidth_d = '0;
      barIndex_d = barIndex_q + 3'd1;
    end else begin
      barWidth_d = barWidth_q + BW'(1);
    end
  end

  always_comb begin
    pattern_d = pattern_q;
    if (enable && atOrigin) begin
      pattern_d = patternSelect;
    end
  end

  always_comb begin
    barColour = 24'h000000;
    case (barIndex_q)
      3'd0:    barColour = 24'hFFFFFF;
      3'd1:    barColour = 24'hFFFF00;
      3'd2:    barColour = 24'h00FFFF;
      3'd3:    barColour = 24'h00FF00;
      3'd4:    barColour = 24'hFF00FF;
      3'd5:    barColour = 24'hFF0000;
      3'd6:    barColour = 24'h0000FF;
      default: barColour = 24'h000000;
    endcase
  end

  always_comb begin
    colour = 24'h808080;
    case (activePattern)
      PAT_BARS:    colour = barColour;
      PAT_GRAD:    colour = {hCount_q[7:0], hCount_q[7:0], hCount_q[7:0]};
      PAT_CHECKER: colour = (hCount_q[4] ^ vCount_q[4]) ? 24'h000000 : 24'hFFFFFF;
      PAT_GREY:    colour = 24'h808080;
      default:     colour = 24'h808080;
    endcase
  end

  // Output decode from the pre-edge counters; disabled cycles decode as blanking.
  always_comb begin
    de_d         = enable && (hCount_q < H_ACT_END) && (vCount_q < V_ACT_END);
    hsync_d      = (enable && (hCount_q >= H_SYNC_START) && (hCount_q < H_SYNC_END))
                   ? HSYNC_POL : ~HSYNC_POL;
    vsync_d      = (enable && (vCount_q >= V_SYNC_START) && (vCount_q < V_SYNC_END))
                   ? VSYNC_POL : ~VSYNC_POL;
    frameStart_d = enable && atOrigin;
    rgb_d        = de_d ? colour : 24'h000000;
  end

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      hCount_q   <= '0;
      vCount_q   <= '0;
      barWidth_q <= '0;
      barIndex_q <= '0;
      pattern_q  <= '0;
    end else begin
      hCount_q   <= hCount_d;
      vCount_q   <= vCount_d;
      barWidth_q <= barWidth_d;
      barIndex_q <= barIndex_d;
      pattern_q  <= pattern_d;
    end
  end

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      de_q         <= 1'b0;
      hsync_q      <= ~HSYNC_POL;
      vsync_q      <= ~VSYNC_POL;
      frameStart_q <= 1'b0;
      rgb_q        <= 24'h000000;
    end else begin
      de_q         <= de_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frameStart_q <= frameStart_d;
      rgb_q        <= rgb_d;
    end
  end

  assign DE         = de_q;
  assign controlBus = {vsync_q, hsync_q};
  assign red        = rgb_q[23:16];
  assign green      = rgb_q[15:8];
  assign blue       = rgb_q[7:0];
  assign frameStart = frameStart_q;

endmodule

// File: tb/tb_video_timing_generator.sv
// Scoreboard bench for video_timing_generator on a reduced 48x27 raster so that
// whole frames, pattern switches, enable drops and async reset fit in a short run.
module tb_video_timing_generator;

  localparam int HA = 32, HFP = 4, HS = 8, HBP = 4, HT = 48;
  localparam int VA = 20, VFP = 2, VS = 2, VBP = 3, VT = 27;
  localparam int BARW = HA / 8;
  localparam int FRAME = HT * VT;

  logic       clk;
  logic       resetN;
  logic       enable;
  logic [1:0] patternSelect;
  logic       DE;
  logic [1:0] controlBus;
  logic [7:0] red, green, blue;
  logic       frameStart;

  int checkCount = 0;
  int failCount  = 0;

  // Expected outputs packed as {DE, controlBus, red, green, blue, frameStart}.
  logic [27:0] sbQueue[$];
  logic [23:0] barTable [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  int         mh, mv;
  logic [1:0] mpat;
  logic       trackPeriod;

  video_timing_generator #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .pixelClock(clk),
    .resetN(resetN),
    .enable(enable),
    .patternSelect(patternSelect),
    .DE(DE),
    .controlBus(controlBus),
    .red(red),
    .green(green),
    .blue(blue),
    .frameStart(frameStart)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [27:0] modelOut(input logic en, input logic [1:0] ps);
    logic       de, fs;
    logic [1:0] cb, pat;
    logic [23:0] c;
    logic [7:0] hb;
    de = 1'b0; fs = 1'b0; cb = 2'b11; c = 24'h0; pat = mpat; hb = 8'(mh);
    if (en) begin
      pat = (mh == 0 && mv == 0) ? ps : mpat;
      fs  = (mh == 0 && mv == 0);
      de  = (mh < HA) && (mv < VA);
      if (mh >= HA + HFP && mh < HA + HFP + HS) cb[0] = 1'b0;
      if (mv >= VA + VFP && mv < VA + VFP + VS) cb[1] = 1'b0;
      if (de) begin
        case (pat)
          2'd0:    c = barTable[mh / BARW];
          2'd1:    c = {hb, hb, hb};
          2'd2:    c = ((((mh >> 4) ^ (mv >> 4)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
          default: c = 24'h808080;
        endcase
      end
    end
    return {de, cb, c, fs};
  endfunction

  task automatic applyStimulus(input logic en, input logic [1:0] ps);
    @(negedge clk);
    enable        = en;
    patternSelect = ps;
    sbQueue.push_back(modelOut(en, ps));
    if (!en) begin
      mh = 0;
      mv = 0;
    end else begin
      if (mh == 0 && mv == 0) mpat = ps;
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
  endtask

  // Monitor: pops one expected word per output cycle, plus frame-level measurements.
  initial begin
    logic [27:0] got, exp;
    logic [1:0]  prevCb;
    logic        seenFs;
    int cyc, deCnt, hsLow, vsLow;
    prevCb = 2'b11; seenFs = 1'b0; cyc = 0; deCnt = 0; hsLow = 0; vsLow = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!trackPeriod) begin
        seenFs = 1'b0;
        prevCb = 2'b11;
      end
      if (sbQueue.size() > 0) begin
        exp = sbQueue.pop_front();
        got = {DE, controlBus, red, green, blue, frameStart};
        checkOutput("pixel", {36'd0, got}, {36'd0, exp});
        if (trackPeriod) begin
          if (got[0]) begin
            if (seenFs) begin
              checkOutput("framePeriod", 64'(cyc), 64'(FRAME));
              checkOutput("deCyclesPerFrame", 64'(deCnt), 64'(HA * VA));
              checkOutput("hsyncLowPerFrame", 64'(hsLow), 64'(HS * VT));
              checkOutput("vsyncLowPerFrame", 64'(vsLow), 64'(VS * HT));
            end
            seenFs = 1'b1;
            cyc = 0; deCnt = 0; hsLow = 0; vsLow = 0;
          end
          if (seenFs) begin
            if (prevCb[0] && !got[25]) checkOutput("hsyncFallIndex", 64'(cyc % HT), 64'(HA + HFP));
            if (prevCb[1] && !got[26]) checkOutput("vsyncFallIndex", 64'(cyc), 64'((VA + VFP) * HT));
            cyc++;
            if (got[27])  deCnt++;
            if (!got[25]) hsLow++;
            if (!got[26]) vsLow++;
          end
          prevCb = got[26:25];
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    failCount++;
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN = 1'b1; enable = 1'b0; patternSelect = 2'd0; trackPeriod = 1'b0;
    mh = 0; mv = 0; mpat = 2'd0;
    #2 resetN = 1'b0;
    #1 checkOutput("resetValues", {36'd0, DE, controlBus, red, green, blue, frameStart},
                   {36'd0, 1'b0, 2'b11, 24'h000000, 1'b0});
    @(negedge clk);
    resetN = 1'b1;
    trackPeriod = 1'b1;

    $display("[TB] colour bars, two full frames");
    repeat (2 * FRAME + 10) applyStimulus(1'b1, 2'd0);

    $display("[TB] checkerboard selected mid-frame at line 10");
    while (!(mh == 0 && mv == 10)) applyStimulus(1'b1, 2'd0);
    repeat (FRAME + 100) applyStimulus(1'b1, 2'd2);

    $display("[TB] gradient then grey");
    repeat (FRAME) applyStimulus(1'b1, 2'd1);
    repeat (FRAME) applyStimulus(1'b1, 2'd3);

    $display("[TB] enable dropped for 5 cycles");
    repeat (17) applyStimulus(1'b1, 2'd3);
    trackPeriod = 1'b0;
    repeat (5) applyStimulus(1'b0, 2'd0);
    trackPeriod = 1'b1;
    repeat (2 * FRAME + 5) applyStimulus(1'b1, 2'd0);

    $display("[TB] async reset at hCount 20, line 5");
    while (!(mh == 20 && mv == 5)) applyStimulus(1'b1, 2'd0);
    @(posedge clk);
    #3;
    trackPeriod = 1'b0;
    enable = 1'b0;
    resetN = 1'b0;
    #1 checkOutput("asyncResetMidLine", {36'd0, DE, controlBus, red, green, blue, frameStart},
                   {36'd0, 1'b0, 2'b11, 24'h000000, 1'b0});
    mh = 0; mv = 0; mpat = 2'd0;
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    trackPeriod = 1'b1;
    repeat (FRAME + 20) applyStimulus(1'b1, 2'd0);

    @(posedge clk);
    #2;
    checkOutput("scoreboardDrained", 64'(sbQueue.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
